enemies_layer_mux: RTL and testbench

Parametrised, registered successor to the two-enemy draw mux. It merges NUM_CH enemy sprite channels into one enemies layer with one pipeline stage, per-channel masking and optional per-frame rotating priority. It also keeps a per-frame sticky record of enemy-on-enemy pixel overlap. It sits between the enemy sprite instances and the top-level objects/background mux.

---
 rtl/enemies_pkg.sv | 13 +
 rtl/enemies_prio_arbiter.sv | 29 ++
 rtl/enemies_layer_mux.sv | 96 +++++++++
 tb/tb_enemies_layer_mux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/enemies_pkg.sv
// Shared types and helpers for the enemy sprite blocks and the enemies layer mux.
package enemies_pkg;

  localparam int MAX_ENEMY_CH = 16;

  typedef logic [7:0] rgb_t;

  // Channel-index width; never below one bit so a 2-channel build still has an index.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/enemies_prio_arbiter.sv
// Combinational wrap-around priority encoder: first set bit of eff at or above ptr,
// wrapping past NUM_CH-1 back to 0.
module enemies_prio_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] eff,
  input  logic [CH_W-1:0]   ptr,
  output logic              valid,
  output logic [CH_W-1:0]   index
);

  always_comb begin : search
    int unsigned j;
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!valid && eff[j]) begin
        valid = 1'b1;
        index = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/enemies_layer_mux.sv
// Registered NUM_CH-channel enemies layer mux with per-frame overlap record.
// Define ENEMIES_ROTATE_PRIO_EN for per-frame rotating priority; default is fixed lowest-index priority.
module enemies_layer_mux
  import enemies_pkg::*;
#(
  parameter int                NUM_CH = 4,
  parameter int                RGB_W  = 8,
  parameter logic [RGB_W-1:0]  BG_RGB = '0,
  localparam int               CH_W   = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic [NUM_CH-1:0]        chDR,
  input  logic [NUM_CH*RGB_W-1:0]  chRGB,
  input  logic [NUM_CH-1:0]        chEnable,
  output logic                     layerDR,
  output logic [RGB_W-1:0]         layerRGB,
  output logic [CH_W-1:0]          layerCh,
  output logic [NUM_CH-1:0]        overlapFlags,
  output logic                     frameOverlap
);

  function automatic logic [CH_W:0] popcount(input logic [NUM_CH-1:0] v);
    logic [CH_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) c = c + (CH_W+1)'(v[i]);
    return c;
  endfunction

  logic [NUM_CH-1:0] eff;
  logic              multi;
  logic [CH_W-1:0]   ptr;
  logic              win_valid;
  logic [CH_W-1:0]   win_idx;
  logic [RGB_W-1:0]  ch_rgb [NUM_CH];
  logic [NUM_CH-1:0] acc;

  assign eff   = chDR & chEnable;
  assign multi = (popcount(eff) >= (CH_W+1)'(2));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_rgb[i] = chRGB[i*RGB_W +: RGB_W];
  end

`ifdef ENEMIES_ROTATE_PRIO_EN
  // Compare against NUM_CH-1 rather than relying on rollover so odd channel counts wrap correctly.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (startOfFrame)
      ptr <= (ptr == CH_W'(NUM_CH-1)) ? '0 : ptr + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  enemies_prio_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arbiter (
    .eff   (eff),
    .ptr   (ptr),
    .valid (win_valid),
    .index (win_idx)
  );

  // NOTE: registers update with <= so each one samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      layerDR  <= 1'b0;
      layerRGB <= '0;
      layerCh  <= '0;
    end else begin
      layerDR  <= win_valid;
      layerRGB <= win_valid ? ch_rgb[win_idx] : BG_RGB;
      layerCh  <= win_valid ? win_idx : '0;
    end
  end

  // The pulse cycle opens the new frame: its overlap seeds acc instead of joining the old record.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      overlapFlags <= '0;
    end else if (startOfFrame) begin
      overlapFlags <= acc;
      acc          <= multi ? eff : '0;
    end else if (multi) begin
      acc <= acc | eff;
    end
  end

  assign frameOverlap = |overlapFlags;

endmodule

// File: tb/tb_enemies_layer_mux.sv
// Directed bench for enemies_layer_mux (NUM_CH=4, RGB_W=8, BG_RGB=0); follows ENEMIES_ROTATE_PRIO_EN.
module tb_enemies_layer_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [3:0]  chDR;
  logic [31:0] chRGB;
  logic [3:0]  chEnable;
  logic        layerDR;
  logic [7:0]  layerRGB;
  logic [1:0]  layerCh;
  logic [3:0]  overlapFlags;
  logic        frameOverlap;

  int tests = 0;
  int fails = 0;

  enemies_layer_mux #(
    .NUM_CH (4),
    .RGB_W  (8),
    .BG_RGB (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .chDR         (chDR),
    .chRGB        (chRGB),
    .chEnable     (chEnable),
    .layerDR      (layerDR),
    .layerRGB     (layerRGB),
    .layerCh      (layerCh),
    .overlapFlags (overlapFlags),
    .frameOverlap (frameOverlap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_layer(input string tag, input logic dr, input logic [7:0] rgb, input logic [1:0] ch);
    check({tag, ".dr"},  32'(layerDR),  32'(dr));
    check({tag, ".rgb"}, 32'(layerRGB), 32'(rgb));
    check({tag, ".ch"},  32'(layerCh),  32'(ch));
  endtask

  task automatic check_ovl(input string tag, input logic [3:0] flags, input logic fo);
    check({tag, ".flags"}, 32'(overlapFlags), 32'(flags));
    check({tag, ".fo"},    32'(frameOverlap), 32'(fo));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sof, input logic [3:0] dr, input logic [3:0] en);
    startOfFrame = sof;
    chDR         = dr;
    chEnable     = en;
  endtask

  initial begin
    chRGB = {8'h3F, 8'hE0, 8'h1C, 8'h11};
    reset = 1'b1;
    drive(1'b0, 4'b1111, 4'b1111);

    // Reset held with all channels requesting, including a coincident frame pulse.
    for (int i = 0; i < 3; i++) begin
      if (i == 1) startOfFrame = 1'b1;
      else        startOfFrame = 1'b0;
      tick();
      check_layer("reset", 1'b0, 8'h00, 2'd0);
      check_ovl("reset", 4'b0000, 1'b0);
    end

    reset = 1'b0;
    drive(1'b0, 4'b0000, 4'b1111);
    tick();
    check_layer("idle", 1'b0, 8'h00, 2'd0);
    check_ovl("idle", 4'b0000, 1'b0);

    // Two requesters: lowest index wins (ptr is 0 since reset in either mode). Seeds acc=0110.
    drive(1'b0, 4'b0110, 4'b1111);
    tick();
    check_layer("fixed_0110", 1'b1, 8'h1C, 2'd1);

    drive(1'b0, 4'b0000, 4'b1111);
    tick();
    check_layer("no_req", 1'b0, 8'h00, 2'd0);

    drive(1'b0, 4'b0110, 4'b1101);
    tick();
    check_layer("masked_ch1", 1'b1, 8'hE0, 2'd2);

    drive(1'b0, 4'b0010, 4'b1101);
    tick();
    check_layer("masked_only", 1'b0, 8'h00, 2'd0);

    drive(1'b0, 4'b1000, 4'b1111);
    tick();
    check_layer("top_ch", 1'b1, 8'h3F, 2'd3);
    check_ovl("midframe_stable", 4'b0000, 1'b0);

    // Frame boundary: record the 0110 overlap seen since reset.
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("sof1", 4'b0110, 1'b1);

    // Frame N: one overlap cycle on 1001, plus a masked would-be overlap.
    drive(1'b0, 4'b1001, 4'b1111);
    tick();
    check_ovl("frameN_hold", 4'b0110, 1'b1);
    drive(1'b0, 4'b1111, 4'b0001);
    tick();
    check_layer("masked_single", 1'b1, 8'h11, 2'd0);
    drive(1'b0, 4'b0000, 4'b1111);
    tick();
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("sof_frameN", 4'b1001, 1'b1);

    // Overlap-free frame clears the record.
    drive(1'b0, 4'b0100, 4'b1111);
    tick();
    check_layer("single_ch2", 1'b1, 8'hE0, 2'd2);
    drive(1'b0, 4'b0100, 4'b1111);
    tick();
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("sof_clear", 4'b0000, 1'b0);

    // Single requests only, one of them from a masked pair.
    drive(1'b0, 4'b0001, 4'b1111);
    tick();
    drive(1'b0, 4'b0010, 4'b1111);
    tick();
    drive(1'b0, 4'b0011, 4'b1110);
    tick();
    check_layer("mask_pair", 1'b1, 8'h1C, 2'd1);
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("sof_singles", 4'b0000, 1'b0);

    // Overlap in the pulse cycle belongs to the new frame.
    drive(1'b1, 4'b0101, 4'b1111);
    tick();
    check_ovl("sof_pulse_overlap", 4'b0000, 1'b0);
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("sof_back2back_a", 4'b0101, 1'b1);
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("sof_back2back_b", 4'b0000, 1'b0);

    // Mid-frame reset discards acc and clears the record.
    drive(1'b0, 4'b0011, 4'b1111);
    tick();
    reset = 1'b1;
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("reset_midframe", 4'b0000, 1'b0);
    check_layer("reset_midframe", 1'b0, 8'h00, 2'd0);
    reset = 1'b0;
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    check_ovl("sof_after_reset", 4'b0000, 1'b0);

    // Fresh reset, then priority after frame pulses. Rotating: ptr=2 then 3 then 0.
    reset = 1'b1;
    drive(1'b0, 4'b0000, 4'b1111);
    tick();
    reset = 1'b0;
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    drive(1'b0, 4'b0011, 4'b1111);
    tick();
    check_layer("ptr2_0011", 1'b1, 8'h11, 2'd0);
    drive(1'b0, 4'b0110, 4'b1111);
    tick();
`ifdef ENEMIES_ROTATE_PRIO_EN
    check_layer("ptr2_0110", 1'b1, 8'hE0, 2'd2);
`else
    check_layer("ptr2_0110", 1'b1, 8'h1C, 2'd1);
`endif
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    drive(1'b0, 4'b1100, 4'b1111);
    tick();
`ifdef ENEMIES_ROTATE_PRIO_EN
    check_layer("ptr3_1100", 1'b1, 8'h3F, 2'd3);
`else
    check_layer("ptr3_1100", 1'b1, 8'hE0, 2'd2);
`endif
    drive(1'b1, 4'b0000, 4'b1111);
    tick();
    drive(1'b0, 4'b1100, 4'b1111);
    tick();
    check_layer("ptr_wrap0_1100", 1'b1, 8'hE0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
